// File: rtl/decode_stage.sv
// RISC-V decode stage: register file, instruction decode,
// load-use hazard detection and a one-entry output register.
module decode_stage #(
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        if_ready_o,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        flush_i,
    input  logic        wb_wen_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [2:0]  format_o,
    output logic        rf_wr_en_o,
    output logic        is_branch_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        illegal_o
);

    localparam int AW = (NUM_REGS == 16) ? 4 : 5;
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        F_NOP = 3'd0,
        F_R   = 3'd1,
        F_I   = 3'd2,
        F_S   = 3'd3,
        F_B   = 3'd4,
        F_U   = 3'd5,
        F_J   = 3'd6
    } fmt_e;

    logic [31:0] rf [NUM_REGS];

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    fmt_e        d_fmt;
    logic [31:0] d_imm;
    logic        use1;
    logic        use2;
    logic        use_rd;
    logic        wr;
    logic        br;
    logic        ld;
    logic        st;
    logic        ill_op;

    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic        d_ill;
    logic        hazard;
    logic        wq;
    logic        slot_free;
    logic [31:0] d_rs1_data;
    logic [31:0] d_rs2_data;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f_rs1 = instr_i[19:15];
    assign f_rs2 = instr_i[24:20];
    assign f_rd  = instr_i[11:7];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    // Classify the opcode: format, used fields, side effects
    always_comb begin
        d_fmt  = F_NOP;
        d_imm  = '0;
        use1   = 1'b0;
        use2   = 1'b0;
        use_rd = 1'b0;
        wr     = 1'b0;
        br     = 1'b0;
        ld     = 1'b0;
        st     = 1'b0;
        ill_op = 1'b0;
        unique case (opc)
            OPC_OP: begin
                d_fmt  = F_R;
                use1   = 1'b1;
                use2   = 1'b1;
                use_rd = 1'b1;
                wr     = 1'b1;
            end
            OPC_IMM: begin
                if (instr_i != 32'h0000_0013) begin
                    d_fmt  = F_I;
                    d_imm  = imm_i;
                    use1   = 1'b1;
                    use_rd = 1'b1;
                    wr     = 1'b1;
                end
            end
            OPC_LOAD: begin
                d_fmt  = F_I;
                d_imm  = imm_i;
                use1   = 1'b1;
                use_rd = 1'b1;
                wr     = 1'b1;
                ld     = 1'b1;
                ill_op = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d_fmt  = F_S;
                d_imm  = imm_s;
                use1   = 1'b1;
                use2   = 1'b1;
                st     = 1'b1;
                ill_op = (f3 >= 3'd3);
            end
            OPC_BRANCH: begin
                d_fmt  = F_B;
                d_imm  = imm_b;
                use1   = 1'b1;
                use2   = 1'b1;
                br     = 1'b1;
                ill_op = (f3[2:1] == 2'b01);
            end
            OPC_JALR: begin
                d_fmt  = F_I;
                d_imm  = imm_i;
                use1   = 1'b1;
                use_rd = 1'b1;
                wr     = 1'b1;
                br     = 1'b1;
                ill_op = (f3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                d_fmt  = F_U;
                d_imm  = imm_u;
                use_rd = 1'b1;
                wr     = 1'b1;
            end
            OPC_JAL: begin
                d_fmt  = F_J;
                d_imm  = imm_j;
                use_rd = 1'b1;
                wr     = 1'b1;
                br     = 1'b1;
            end
            OPC_SYSTEM: begin
                d_fmt = F_NOP;
            end
            default: begin
                ill_op = 1'b1;
            end
        endcase
    end

    assign d_rs1 = use1 ? f_rs1 : 5'd0;
    assign d_rs2 = use2 ? f_rs2 : 5'd0;
    assign d_rd  = use_rd ? f_rd : 5'd0;

    assign d_ill = ill_op
                || (instr_i[1:0] != 2'b11)
                || ({1'b0, d_rs1} >= NREG)
                || ({1'b0, d_rs2} >= NREG)
                || ({1'b0, d_rd} >= NREG);

    assign hazard = ex_is_load_i && (ex_rd_i != 5'd0)
                 && ((use1 && f_rs1 == ex_rd_i)
                  || (use2 && f_rs2 == ex_rd_i));

    assign wq = wb_wen_i && (wb_rd_i != 5'd0)
             && ({1'b0, wb_rd_i} < NREG);

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        logic [31:0] v;
        v = '0;
        if (idx != 5'd0 && {1'b0, idx} < NREG) begin
            if (BYPASS_EN != 0 && wq && wb_rd_i == idx) begin
                v = wb_data_i;
            end else begin
                v = rf[idx[AW-1:0]];
            end
        end
        return v;
    endfunction

    // Operand fetch with optional writeback forwarding
    always_comb begin
        d_rs1_data = rf_read(d_rs1);
        d_rs2_data = rf_read(d_rs2);
    end

    assign slot_free  = !ex_valid_o || ex_ready_i;
    assign if_ready_o = rst && (flush_i || (slot_free && !hazard));

    // Register file: cleared in reset, x0 never written
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wq) begin
            rf[wb_rd_i[AW-1:0]] <= wb_data_i;
        end
    end

    // Output slot: flush beats accept, bubble on hazard, hold on stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_o  <= 1'b0;
            pc_o        <= '0;
            instr_o     <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            imm_o       <= '0;
            format_o    <= '0;
            rf_wr_en_o  <= 1'b0;
            is_branch_o <= 1'b0;
            is_load_o   <= 1'b0;
            is_store_o  <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (slot_free) begin
            if (if_valid_i && !hazard) begin
                ex_valid_o  <= 1'b1;
                pc_o        <= pc_i;
                instr_o     <= instr_i;
                rs1_o       <= d_rs1;
                rs2_o       <= d_rs2;
                rd_o        <= d_rd;
                rs1_data_o  <= d_rs1_data;
                rs2_data_o  <= d_rs2_data;
                imm_o       <= d_imm;
                format_o    <= d_fmt;
                rf_wr_en_o  <= wr && (d_rd != 5'd0) && !d_ill;
                is_branch_o <= br && !d_ill;
                is_load_o   <= ld && !d_ill;
                is_store_o  <= st && !d_ill;
                illegal_o   <= d_ill;
            end else begin
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I+bypass and RV32E without bypass
// side by side, checked against a rule-level decode model.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        wen;
        logic        br;
        logic        ld;
        logic        st;
        logic        ill;
    } bnd_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ex_ready;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        a_rdy, b_rdy, a_v, b_v;
    logic [31:0] a_pc, b_pc, a_in, b_in;
    logic [4:0]  a_rs1, b_rs1, a_rs2, b_rs2, a_rd, b_rd;
    logic [31:0] a_d1, b_d1, a_d2, b_d2, a_imm, b_imm;
    logic [2:0]  a_fmt, b_fmt;
    logic        a_wen, b_wen, a_br, b_br, a_ld, b_ld;
    logic        a_st, b_st, a_ill, b_ill;

    bnd_t oa, ob, ea, eb, la, lb;

    logic [31:0] m [2][32];
    int n_chk = 0;
    int n_fail = 0;

    assign oa = {a_v, a_pc, a_in, a_rs1, a_rs2, a_rd, a_d1, a_d2,
                 a_imm, a_fmt, a_wen, a_br, a_ld, a_st, a_ill};
    assign ob = {b_v, b_pc, b_in, b_rs1, b_rs2, b_rd, b_d1, b_d2,
                 b_imm, b_fmt, b_wen, b_br, b_ld, b_st, b_ill};

    decode_stage dut_a (
        .clk(clk), .rst(rst), .if_valid_i(if_valid),
        .instr_i(instr), .pc_i(pc), .if_ready_o(a_rdy),
        .ex_valid_o(a_v), .ex_ready_i(ex_ready),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
        .flush_i(flush), .wb_wen_i(wb_wen), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .pc_o(a_pc), .instr_o(a_in),
        .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .rs1_data_o(a_d1), .rs2_data_o(a_d2), .imm_o(a_imm),
        .format_o(a_fmt), .rf_wr_en_o(a_wen),
        .is_branch_o(a_br), .is_load_o(a_ld),
        .is_store_o(a_st), .illegal_o(a_ill)
    );

    decode_stage #(.NUM_REGS(16), .BYPASS_EN(0)) dut_b (
        .clk(clk), .rst(rst), .if_valid_i(if_valid),
        .instr_i(instr), .pc_i(pc), .if_ready_o(b_rdy),
        .ex_valid_o(b_v), .ex_ready_i(ex_ready),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
        .flush_i(flush), .wb_wen_i(wb_wen), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .pc_o(b_pc), .instr_o(b_in),
        .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .rs1_data_o(b_d1), .rs2_data_o(b_d2), .imm_o(b_imm),
        .format_o(b_fmt), .rf_wr_en_o(b_wen),
        .is_branch_o(b_br), .is_load_o(b_ld),
        .is_store_o(b_st), .illegal_o(b_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nr_of(int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] mrd(int k, logic [4:0] idx);
        if (idx == 0 || idx >= nr_of(k)) return 32'h0;
        if (k == 0 && wb_wen && wb_rd == idx) return wb_data;
        return m[k][idx];
    endfunction

    function automatic bnd_t model(int k, logic [31:0] ins,
                                   logic [31:0] p);
        bnd_t e;
        bit u1, u2, ud, wr, bad;
        int f3;
        int sgn;
        logic [31:0] imm;
        e = '0;
        e.valid = 1'b1;
        e.pc = p;
        e.instr = ins;
        u1 = 0; u2 = 0; ud = 0; wr = 0; bad = 0;
        imm = 0;
        f3 = int'(ins[14:12]);
        sgn = ins[31] ? 1 : 0;
        case (ins[6:0])
            7'h33: begin
                e.fmt = 1; u1 = 1; u2 = 1; ud = 1; wr = 1;
            end
            7'h13: begin
                if (ins != 32'h13) begin
                    e.fmt = 2; u1 = 1; ud = 1; wr = 1;
                    imm = -2048 * sgn + ins[30:20];
                end
            end
            7'h03: begin
                e.fmt = 2; u1 = 1; ud = 1; wr = 1; e.ld = 1;
                imm = -2048 * sgn + ins[30:20];
                bad = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin
                e.fmt = 3; u1 = 1; u2 = 1; e.st = 1;
                imm = -2048 * sgn + ins[30:25] * 32 + ins[11:7];
                bad = (f3 >= 3);
            end
            7'h63: begin
                e.fmt = 4; u1 = 1; u2 = 1; e.br = 1;
                imm = -4096 * sgn + ins[7] * 2048
                    + ins[30:25] * 32 + ins[11:8] * 2;
                bad = (f3 == 2 || f3 == 3);
            end
            7'h67: begin
                e.fmt = 2; u1 = 1; ud = 1; wr = 1; e.br = 1;
                imm = -2048 * sgn + ins[30:20];
                bad = (f3 != 0);
            end
            7'h37, 7'h17: begin
                e.fmt = 5; ud = 1; wr = 1;
                imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.fmt = 6; ud = 1; wr = 1; e.br = 1;
                imm = -(1 << 20) * sgn + ins[19:12] * 4096
                    + ins[20] * 2048 + ins[30:21] * 2;
            end
            7'h73: begin
                e.fmt = 0;
            end
            default: bad = 1;
        endcase
        e.imm = imm;
        e.rs1 = u1 ? ins[19:15] : 5'd0;
        e.rs2 = u2 ? ins[24:20] : 5'd0;
        e.rd  = ud ? ins[11:7] : 5'd0;
        if (e.rs1 >= nr_of(k) || e.rs2 >= nr_of(k)
            || e.rd >= nr_of(k)) bad = 1;
        if (ins[1:0] != 2'b11) bad = 1;
        e.d1 = mrd(k, e.rs1);
        e.d2 = mrd(k, e.rs2);
        e.wen = wr && e.rd != 0 && !bad;
        e.br = e.br && !bad;
        e.ld = e.ld && !bad;
        e.st = e.st && !bad;
        e.ill = bad;
        return e;
    endfunction

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
            end else if (wb_wen && wb_rd != 0 && wb_rd < nr_of(k)) begin
                m[k][wb_rd] = wb_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(string tag, bnd_t o, bnd_t e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic chk_w(string tag, logic [31:0] o, logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic accept(logic [31:0] ins, logic [31:0] p, string tag);
        if_valid = 1'b1;
        instr = ins;
        pc = p;
        ea = model(0, ins, p);
        eb = model(1, ins, p);
        la = ea;
        lb = eb;
        tick();
        chk_b({tag, "_a"}, oa, ea);
        chk_b({tag, "_b"}, ob, eb);
        if_valid = 1'b0;
    endtask

    logic [31:0] ill_list [10];
    logic [6:0]  opc_tab [10];

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        ill_list = '{32'h0000_007F, 32'h0000_0000, 32'h0000_3003,
                     32'h0000_7023, 32'h0000_2063, 32'h0000_1067,
                     32'h0000_0073, 32'h0000_0013, 32'h1234_5037,
                     32'h0080_006F};
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37,
                    7'h17, 7'h6F, 7'h67, 7'h63, 7'h73};
        rst = 0; if_valid = 0; instr = 0; pc = 0;
        ex_ready = 1; ex_is_load = 0; ex_rd = 0; flush = 0;
        wb_wen = 0; wb_rd = 0; wb_data = 0;
        tick();
        tick();
        chk_b("rst_a", oa, '0);
        chk_b("rst_b", ob, '0);
        chk_w("rst_rdy", {31'h0, a_rdy}, 32'h0);
        rst = 1;

        wb_wen = 1; wb_rd = 5; wb_data = 32'h1234_5678;
        tick();
        wb_wen = 0;
        accept(32'h0052_8333, 32'h100, "add");
        chk_w("add_d1", a_d1, 32'h1234_5678);
        chk_w("add_d2", a_d2, 32'h1234_5678);
        chk_w("add_rd", {27'h0, a_rd}, 32'd6);
        chk_w("add_fmt", {29'h0, a_fmt}, 32'd1);

        wb_wen = 1; wb_rd = 7; wb_data = 32'hCAFE_F00D;
        accept(32'h0003_8413, 32'h104, "byp");
        wb_wen = 0;
        chk_w("byp_on", a_d1, 32'hCAFE_F00D);
        chk_w("byp_off", b_d1, 32'h0);

        accept(32'hFE00_0EE3, 32'h108, "beq");
        chk_w("beq_imm", a_imm, 32'hFFFF_FFFC);
        chk_w("beq_fmt", {29'h0, a_fmt}, 32'd4);
        chk_w("beq_br", {31'h0, a_br}, 32'd1);

        ex_is_load = 1; ex_rd = 5;
        if_valid = 1; instr = 32'h0052_8333; pc = 32'h10C;
        #1;
        chk_w("haz_rdy", {31'h0, a_rdy}, 32'h0);
        tick();
        chk_w("haz_bub_a", {31'h0, a_v}, 32'h0);
        chk_w("haz_bub_b", {31'h0, b_v}, 32'h0);
        ex_is_load = 0;
        #1;
        chk_w("haz_rel", {31'h0, a_rdy}, 32'h1);
        accept(32'h0052_8333, 32'h10C, "haz_acc");

        accept(32'h00A0_0093, 32'h110, "hold0");
        ex_ready = 0;
        if_valid = 1; instr = 32'h0052_8333; pc = 32'h114;
        repeat (3) begin
            tick();
            chk_b("hold_a", oa, la);
            chk_b("hold_b", ob, lb);
            chk_w("hold_rdy", {31'h0, a_rdy}, 32'h0);
        end
        flush = 1;
        #1;
        chk_w("fl_rdy", {31'h0, a_rdy}, 32'h1);
        tick();
        chk_w("fl_v_a", {31'h0, a_v}, 32'h0);
        chk_w("fl_v_b", {31'h0, b_v}, 32'h0);
        flush = 0; ex_ready = 1; if_valid = 0;
        tick();
        chk_w("fl_gone", {31'h0, a_v}, 32'h0);

        accept(32'h0010_0893, 32'h118, "rv32e");
        chk_w("e_ill", {31'h0, b_ill}, 32'h1);
        chk_w("e_wen", {31'h0, b_wen}, 32'h0);
        chk_w("i_wen", {31'h0, a_wen}, 32'h1);
        wb_wen = 1; wb_rd = 20; wb_data = 32'hA5A5_0020;
        tick();
        wb_wen = 0;
        accept(32'h0142_04B3, 32'h11C, "e_drop");
        chk_w("e_x4", b_d1, 32'h0);
        chk_w("i_x20", a_d2, 32'hA5A5_0020);

        foreach (ill_list[i]) begin
            accept(ill_list[i], 32'h200 + 32'(i * 4), "dir");
        end

        accept(32'h0052_8333, 32'h300, "pre_rst");
        ex_ready = 0;
        rst = 0;
        #1;
        chk_w("rst_rdy2", {31'h0, a_rdy}, 32'h0);
        tick();
        chk_b("mid_rst_a", oa, '0);
        chk_b("mid_rst_b", ob, '0);
        rst = 1; ex_ready = 1;
        tick();
        tick();
        chk_w("post_rst", {31'h0, a_v}, 32'h0);
        accept(32'h0052_8333, 32'h304, "rf_clr");
        chk_w("rf_clr_d", a_d1, 32'h0);

        for (int it = 0; it < 200; it++) begin
            r = $urandom();
            ins = r;
            if ($urandom_range(0, 9) != 0) begin
                ins[6:0] = opc_tab[$urandom_range(0, 9)];
            end
            wb_wen = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 31));
            wb_data = $urandom();
            accept(ins, $urandom(), "rnd");
        end
        wb_wen = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NUM_REGS, default 32, architectural register count; the only legal values are 32 (RV32I) and 16 (RV32E).
REQ-002 Parameter BYPASS_EN, default 1; when 1, a same-cycle writeback is forwarded to the register reads.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 if_valid_i  in  1  fetch holds an instruction.
REQ-006 instr_i  in  32  instruction word.
REQ-007 pc_i  in  32  PC of instr_i.
REQ-008 if_ready_o  out  1  stage accepts instr_i this cycle.
REQ-009 ex_valid_o  out  1  decoded bundle is valid.
REQ-010 ex_ready_i  in  1  execute consumes the bundle.
REQ-011 ex_is_load_i, ex_rd_i  in  1, 5  load currently occupying execute, and its rd.
REQ-012 flush_i  in  1  kill the held and incoming instruction.
REQ-013 wb_wen_i, wb_rd_i, wb_data_i  in  1, 5, 32  register writeback.
REQ-014 Registered outputs: pc_o 32, instr_o 32, rs1_o/rs2_o/rd_o 5 each, rs1_data_o/rs2_data_o 32 each, imm_o 32, format_o 3, rf_wr_en_o 1, is_branch_o 1, is_load_o 1, is_store_o 1, illegal_o 1.
REQ-015 format_o encoding: NOP=0, R=1, I=2, S=3, B=4, U=5, J=6.

Function
REQ-016 The stage SHALL contain a NUM_REGS x 32 register file with x0 reading as 0 and ignoring writes.
REQ-017 Writes SHALL occur when wb_wen_i=1, wb_rd_i!=0 and wb_rd_i<NUM_REGS; all other writes are dropped.
REQ-018 With BYPASS_EN=1, a read whose index matches a same-cycle qualified write SHALL return wb_data_i; with BYPASS_EN=0 it SHALL return the old value.
REQ-019 Accept condition is if_valid_i && if_ready_o; an accepted instruction SHALL appear on the outputs with ex_valid_o=1 exactly one cycle later (latency 1).
REQ-020 if_ready_o SHALL equal (!ex_valid_o || ex_ready_i) && !hazard, and SHALL be 1 when flush_i=1.
REQ-021 hazard SHALL be asserted when ex_is_load_i=1, ex_rd_i!=0, and ex_rd_i equals a source register actually used by instr_i (R, S, B use rs1 and rs2; I, load and JALR use rs1).
REQ-022 On a hazard with the output slot free or being consumed, the stage SHALL load a bubble (ex_valid_o=0) and hold fetch.
REQ-023 While ex_valid_o=1 and ex_ready_i=0, all outputs SHALL hold stable.
REQ-024 flush_i=1 SHALL clear ex_valid_o on the next edge, discard instr_i, and take priority over accept, hold and hazard.
REQ-025 Decoding SHALL cover opcodes OP-IMM, OP, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH and SYSTEM/E_OP; SYSTEM SHALL decode as format NOP with no side effects.
REQ-026 imm_o SHALL be sign-extended per format: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; zero for R and NOP.
REQ-027 Unused register fields SHALL output as 0 (for example rs2_o for I-type, rs1_o/rs2_o for U/J).
REQ-028 rf_wr_en_o SHALL be 1 only for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR with rd!=0.
REQ-029 addi x0,x0,0 (0x00000013) SHALL decode as format NOP with rf_wr_en_o=0.
REQ-030 is_branch_o SHALL be 1 for BRANCH, JAL and JALR; is_load_o/is_store_o SHALL be 1 for LOAD/STORE.
REQ-031 illegal_o=1 SHALL be raised for: an unknown opcode; instr_i[1:0]!=2'b11; LOAD funct3 in {3,6,7}; STORE funct3 >= 3; BRANCH funct3 in {2,3}; JALR funct3!=0; any used register index >= NUM_REGS.
REQ-032 An illegal instruction SHALL still be passed through with ex_valid_o=1, and with rf_wr_en_o, is_branch_o, is_load_o and is_store_o all forced to 0.

Reset
REQ-033 While rst=0 at an edge, ex_valid_o and every registered output SHALL become 0 and all register-file entries SHALL become 0.
REQ-034 While rst=0, if_ready_o SHALL be 0.
REQ-035 Reset asserted mid-stall or mid-hold SHALL discard the pending bundle; no output is produced after release until a new accept.

Verification
REQ-036 Write x5=0x12345678, then accept add x6,x5,x5 (0x00528333) -> next cycle ex_valid_o=1, rs1_data_o=rs2_data_o=0x12345678, rd_o=6, format_o=1, rf_wr_en_o=1.
REQ-037 Present ex_is_load_i=1, ex_rd_i=5 and instr_i=0x00528333 -> if_ready_o=0 and a bubble is inserted; deassert ex_is_load_i -> accepted next cycle.
REQ-038 Hold ex_ready_i=0 for 3 cycles with a valid bundle -> outputs are unchanged, if_ready_o=0; raise flush_i -> ex_valid_o=0 the next cycle.
REQ-039 NUM_REGS=16: accept addi x17,x0,1 -> illegal_o=1, rf_wr_en_o=0; wb_rd_i=20 write is dropped.
REQ-040 Same-cycle write x7=0xCAFEF00D and read of x7 -> with BYPASS_EN=1 returns 0xCAFEF00D; with BYPASS_EN=0 returns 0.
REQ-041 beq with offset -4 (0xFE000EE3) -> imm_o=0xFFFFFFFC, format_o=4, is_branch_o=1.
